// File: rtl/lfs_pkg.sv
// Shared types and derived constants for the line feed scheduler.
// LINE_FEED_PAD_EN adds an all-zero line before and after the source frame.
package lfs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } lfs_state_e;

  function automatic int col_w(input int img_width);
    return (img_width > 1) ? $clog2(img_width) : 1;
  endfunction

  function automatic int cnt_w(input int img_height);
    return $clog2(img_height + 3);
  endfunction

  function automatic int credit_w(input int prefill_lines);
    return $clog2(prefill_lines + 1);
  endfunction

`ifdef LINE_FEED_PAD_EN
  // Two synthetic zero lines surround the frame, so the 3x3 window yields one output line per source line.
  function automatic int total_lines(input int img_height);
    return img_height + 2;
  endfunction

  function automatic int expected_intr(input int img_height);
    return img_height;
  endfunction
`else
  function automatic int total_lines(input int img_height);
    return img_height;
  endfunction

  function automatic int expected_intr(input int img_height);
    return img_height - 2;
  endfunction
`endif

endpackage

// File: rtl/lfs_credit_counter.sv
// Line credit counter: one credit per line the window controller can still buffer.
// Simultaneous release and consumption cancel; a release at full credit is flagged as an error.
module lfs_credit_counter #(
  parameter int PREFILL_LINES = 4,
  parameter int CRED_W        = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic              dec_i,
  input  logic              bad_i,
  output logic [CRED_W-1:0] credit_o,
  output logic              err_o
);

  localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(PREFILL_LINES);

  logic [CRED_W-1:0] credit_q, credit_d;
  logic              err_q, err_d;

  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    if (load_i) begin
      credit_d = CRED_FULL;
      err_d    = 1'b0;
    end else begin
      if (inc_i && !dec_i) begin
        if (credit_q == CRED_FULL) begin
          err_d = 1'b1;
        end else begin
          credit_d = credit_q + 1'b1;
        end
      end else if (dec_i && !inc_i && (credit_q != '0)) begin
        credit_d = credit_q - 1'b1;
      end
      if (bad_i) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      credit_q <= '0;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign credit_o = credit_q;
  assign err_o    = err_q;

endmodule

// File: rtl/line_feed_scheduler.sv
// Meters the source pixel stream into the 4-line window controller using line credits.
// LINE_FEED_PAD_EN: emit one all-zero line before the first and after the last source line.
module line_feed_scheduler
  import lfs_pkg::*;
#(
  parameter int IMG_WIDTH     = 512,
  parameter int IMG_HEIGHT    = 512,
  parameter int PREFILL_LINES = 4,
  parameter int DATA_W        = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_src_data,
  input  logic              i_src_valid,
  output logic              o_src_ready,
  output logic [DATA_W-1:0] o_pix_data,
  output logic              o_pix_valid,
  input  logic              i_lb_intr,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_err_intr
);

  localparam int COL_W  = col_w(IMG_WIDTH);
  localparam int CNT_W  = cnt_w(IMG_HEIGHT);
  localparam int CRED_W = credit_w(PREFILL_LINES);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(total_lines(IMG_HEIGHT) - 1);
  localparam logic [CNT_W-1:0] INTR_EXP  = CNT_W'(expected_intr(IMG_HEIGHT));

  lfs_state_e        state_q;
  logic [COL_W-1:0]  col_q;
  logic [CNT_W-1:0]  line_q;
  logic [CNT_W-1:0]  intr_q;
  logic [DATA_W-1:0] pix_data_q;
  logic              pix_valid_q;

  logic [CRED_W-1:0] credit;
  logic              busy;
  logic              in_feed;
  logic              has_credit;
  logic              pad_line;
  logic              adv;
  logic              line_done;
  logic              intr_cnt_inc;
  logic [CNT_W-1:0]  intr_d;

  assign busy       = (state_q == FEED) || (state_q == DRAIN);
  assign in_feed    = (state_q == FEED);
  assign has_credit = (credit != '0);

`ifdef LINE_FEED_PAD_EN
  assign pad_line = (line_q == '0) || (line_q == LINE_LAST);
`else
  assign pad_line = 1'b0;
`endif

  // Pad lines advance one pixel per cycle on their own; source lines advance on handshake.
  assign o_src_ready  = in_feed && has_credit && !pad_line;
  assign adv          = in_feed && has_credit && (pad_line || i_src_valid);
  assign line_done    = adv && (col_q == COL_LAST);
  assign intr_cnt_inc = i_lb_intr && busy;
  assign intr_d       = intr_q + CNT_W'(intr_cnt_inc);

  lfs_credit_counter #(
    .PREFILL_LINES (PREFILL_LINES),
    .CRED_W        (CRED_W)
  ) u_credit (
    .clk_i    (i_clk),
    .rst_n_i  (i_rst_n),
    .load_i   ((state_q == IDLE) && i_start),
    .inc_i    (intr_cnt_inc),
    .dec_i    (line_done),
    .bad_i    (i_lb_intr && !busy),
    .credit_o (credit),
    .err_o    (o_err_intr)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      line_q      <= '0;
      intr_q      <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      pix_valid_q <= adv;
      if (adv) begin
        pix_data_q <= pad_line ? '0 : i_src_data;
      end
      if (busy) begin
        intr_q <= intr_d;
      end
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q <= FEED;
            col_q   <= '0;
            line_q  <= '0;
            intr_q  <= '0;
          end
        end
        FEED: begin
          if (adv) begin
            if (col_q == COL_LAST) begin
              col_q  <= '0;
              line_q <= line_q + 1'b1;
              if (line_q == LINE_LAST) begin
                state_q <= DRAIN;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        // An interrupt arriving this cycle counts toward completion.
        DRAIN: begin
          if (intr_d >= INTR_EXP) begin
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_pix_data   = pix_data_q;
  assign o_pix_valid  = pix_valid_q;
  assign o_busy       = busy;
  assign o_frame_done = (state_q == DONE);

endmodule

// File: tb/tb_line_feed_scheduler.sv
// Directed + randomized bench for line_feed_scheduler against a count-based frame model.
// Build with LINE_FEED_PAD_EN defined to exercise the padded frame.
module tb_line_feed_scheduler;

  localparam int W = 8;
  localparam int H = 6;
  localparam int P = 4;
`ifdef LINE_FEED_PAD_EN
  localparam bit PAD   = 1'b1;
  localparam int TOTAL = H + 2;
  localparam int EXP   = H;
`else
  localparam bit PAD   = 1'b0;
  localparam int TOTAL = H;
  localparam int EXP   = H - 2;
`endif

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_start;
  logic [7:0] i_src_data;
  logic       i_src_valid;
  logic       o_src_ready;
  logic [7:0] o_pix_data;
  logic       o_pix_valid;
  logic       i_lb_intr;
  logic       o_busy;
  logic       o_frame_done;
  logic       o_err_intr;

  line_feed_scheduler #(
    .IMG_WIDTH     (W),
    .IMG_HEIGHT    (H),
    .PREFILL_LINES (P),
    .DATA_W        (8)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_src_data   (i_src_data),
    .i_src_valid  (i_src_valid),
    .o_src_ready  (o_src_ready),
    .o_pix_data   (o_pix_data),
    .o_pix_valid  (o_pix_valid),
    .i_lb_intr    (i_lb_intr),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_err_intr   (o_err_intr)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Frame model: pixels emitted, interrupts counted, and flags derived from them.
  int       m_out = 0;
  int       m_intr = 0;
  bit       m_busy = 1'b0;
  bit       m_dcyc = 1'b0;
  bit       m_err = 1'b0;
  bit       exp_v = 1'b0;
  bit [7:0] exp_d = 8'h00;
  int       pix_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_pad(input int ln);
    return PAD && ((ln == 0) || (ln == TOTAL - 1));
  endfunction

  function automatic bit can_adv(input bit v);
    int ln;
    ln = m_out / W;
    return m_busy && (m_out < TOTAL * W) && (ln < P + m_intr) && (is_pad(ln) || v);
  endfunction

  // One clock cycle: check outputs at the falling edge, drive inputs, update the model at the rising edge.
  task automatic tick(input bit v, input bit intr, input bit start);
    int ln;
    bit rdy_e;
    bit adv;
    bit drained;
    bit was_idle;
    bit new_dcyc;
    ln    = m_out / W;
    rdy_e = m_busy && (m_out < TOTAL * W) && (ln < P + m_intr) && !is_pad(ln);
    chk("src_ready", o_src_ready, rdy_e);
    chk("pix_valid", o_pix_valid, exp_v);
    if (exp_v) chk("pix_data", o_pix_data, exp_d);
    if (o_pix_valid === 1'b1) pix_seen++;
    chk("busy", o_busy, m_busy);
    chk("frame_done", o_frame_done, m_dcyc);
    chk("err_intr", o_err_intr, m_err);
    i_src_valid = v;
    i_src_data  = 8'($urandom);
    i_lb_intr   = intr;
    i_start     = start;
    @(posedge clk);
    adv      = can_adv(v);
    exp_v    = adv;
    exp_d    = is_pad(ln) ? 8'h00 : i_src_data;
    drained  = m_busy && (m_out == TOTAL * W);
    was_idle = !m_busy && !m_dcyc;
    new_dcyc = 1'b0;
    if (adv) m_out++;
    if (intr) begin
      if (m_busy) m_intr++;
      else m_err = 1'b1;
    end
    if (drained && (m_intr >= EXP)) begin
      m_busy   = 1'b0;
      new_dcyc = 1'b1;
    end
    if (start && was_idle) begin
      m_busy = 1'b1;
      m_out  = 0;
      m_intr = 0;
      m_err  = 1'b0;
    end
    m_dcyc = new_dcyc;
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_dcyc = 1'b0;
    m_err  = 1'b0;
    m_out  = 0;
    m_intr = 0;
    exp_v  = 1'b0;
    exp_d  = 8'h00;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_src_ready"}, o_src_ready, 1'b0);
    chk({tag, "_pix_valid"}, o_pix_valid, 1'b0);
    chk({tag, "_pix_data"}, o_pix_data, 8'h00);
    chk({tag, "_busy"}, o_busy, 1'b0);
    chk({tag, "_frame_done"}, o_frame_done, 1'b0);
    chk({tag, "_err"}, o_err_intr, 1'b0);
  endtask

  initial begin
    int  cycles;
    bit  sim_done;
    bit  v;
    bit  intr;
    int  ln;

    i_rst_n     = 1'b0;
    i_start     = 1'b0;
    i_src_data  = 8'h00;
    i_src_valid = 1'b0;
    i_lb_intr   = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    i_rst_n = 1'b1;

    // Interrupt while idle is an error; the next start clears it.
    tick(1'b0, 1'b1, 1'b0);
    chk("idle_intr_err", o_err_intr, 1'b1);

    // Frame A: prefill, credit release per interrupt, drain, completion.
    pix_seen = 0;
    tick(1'b0, 1'b0, 1'b1);
    chk("start_busy", o_busy, 1'b1);
    repeat (40) tick(1'b1, 1'b0, 1'b0);
    chk("prefill_count", pix_seen, P * W);
    chk("prefill_stall", o_src_ready, 1'b0);
    while (m_out < TOTAL * W) begin
      tick(1'b1, 1'b1, 1'b0);
      repeat (12) tick(1'b1, 1'b0, 1'b0);
    end
    chk("release_count", pix_seen, TOTAL * W);
    chk("drain_busy", o_busy, 1'b1);
    chk("drain_ready", o_src_ready, 1'b0);
    while (m_intr < EXP) begin
      repeat (3) tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
    end
    chk("done_pulse", o_frame_done, 1'b1);
    chk("done_busy", o_busy, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("done_one_cycle", o_frame_done, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    chk("late_intr_err", o_err_intr, 1'b1);

    // Frame B: random source stalls and interrupts, with one interrupt on a line-completing handshake.
    pix_seen = 0;
    sim_done = 1'b0;
    cycles   = 0;
    tick(1'b0, 1'b0, 1'b1);
    chk("restart_err_clear", o_err_intr, 1'b0);
    while ((m_busy || m_dcyc) && (cycles < 3000)) begin
      ln   = m_out / W;
      v    = ($urandom_range(0, 2) != 0);
      intr = 1'b0;
      if (m_busy && (m_intr < EXP) && (m_intr < ln)) begin
        if (!sim_done && (m_out % W == W - 1) && can_adv(v)) begin
          intr     = 1'b1;
          sim_done = 1'b1;
        end else begin
          intr = ($urandom_range(0, 5) == 0);
        end
      end
      tick(v, intr, 1'b0);
      cycles++;
    end
    chk("frameB_finished", (cycles < 3000), 1'b1);
    chk("frameB_pixels", pix_seen, TOTAL * W);
    chk("frameB_no_err", o_err_intr, 1'b0);

    // Frame C: asynchronous reset mid-frame, then a clean restart.
    tick(1'b0, 1'b0, 1'b1);
    while (m_out < 13) tick(1'b1, 1'b0, 1'b0);
    i_rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    pix_seen = 0;
    tick(1'b0, 1'b0, 1'b1);
    repeat (40) tick(1'b1, 1'b0, 1'b0);
    chk("restart_prefill", pix_seen, P * W);
    chk("restart_stall", o_src_ready, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/line_feed_scheduler.md
# line_feed_scheduler

Frame-level sequencer that meters the incoming pixel stream into the 4-line-buffer window controller using line credits. It prefills four lines, then releases one further line per line-consumed interrupt from the window controller, and signals frame completion. It sits between the pixel source (DMA/FIFO) and the window controller's pixel input.

## Interface
- IMG_WIDTH, 512, pixels per line
- IMG_HEIGHT, 512, source lines per frame (≥3)
- PREFILL_LINES, 4, initial line credit; equals the line-buffer count
- DATA_W, 8, pixel width
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  frame start pulse; honoured only in IDLE
- i_src_data  in  DATA_W  source pixel
- i_src_valid  in  1  source pixel valid
- o_src_ready  out  1  scheduler accepts source pixel this cycle
- o_pix_data  out  DATA_W  pixel to window controller (registered)
- o_pix_valid  out  1  pixel valid to window controller (registered)
- i_lb_intr  in  1  one-cycle pulse per output line consumed by the window controller
- o_busy  out  1  frame in progress
- o_frame_done  out  1  one-cycle pulse at frame completion
- o_err_intr  out  1  sticky: i_lb_intr arrived with credit already at PREFILL_LINES, or while not busy

## Operation
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE: o_src_ready=0. On i_start, enter FEED. Load credit=PREFILL_LINES and clear col, line_cnt, intr_cnt and o_err_intr.
- FEED:
  - o_src_ready = (credit>0). A handshake (i_src_valid & o_src_ready) forwards the pixel and increments col.
  - At col==IMG_WIDTH-1 with handshake: col wraps to 0, line_cnt++, credit--.
  - When the last line completes (line_cnt reaches total lines), enter DRAIN.
- i_lb_intr while busy: intr_cnt++, credit++.
  - If credit==PREFILL_LINES and no simultaneous line completion, credit holds and o_err_intr is set.
  - A simultaneous line completion and intr leaves credit unchanged.
- DRAIN: o_src_ready=0. When intr_cnt reaches the expected count (including an intr in the same cycle), enter DONE.
- DONE: lasts one cycle, o_frame_done=1, then IDLE.
- Total lines = IMG_HEIGHT. Expected interrupts = IMG_HEIGHT−2 (3×3 window).
- i_lb_intr in IDLE/DONE: ignored for counting, sets o_err_intr.
- i_start while busy: ignored.
- Downstream never back-pressures. The source may stall freely via i_src_valid.
- Widths:
  - col: $clog2(IMG_WIDTH).
  - line_cnt and intr_cnt: $clog2(IMG_HEIGHT+3).
  - credit: $clog2(PREFILL_LINES+1).
  - All counters wrap-free by construction.

## Timing
- Reset values: o_src_ready=0, o_pix_valid=0, o_pix_data=0, o_busy=0, o_frame_done=0, o_err_intr=0, state IDLE.
- Assertion of i_rst_n mid-frame aborts immediately. No frame_done is issued.
- i_start at cycle t gives state FEED and o_busy=1 at t+1. o_src_ready may be high at t+1.
- Pixel latency: handshake at cycle t gives o_pix_valid/o_pix_data at t+1.
- o_src_ready is a combinational function of registered state and credit only, never of i_src_valid.
- o_busy=1 in FEED and DRAIN, 0 in DONE.
- o_frame_done is high the cycle after the final expected i_lb_intr.
- Credit that reaches 0 drops o_src_ready in the same cycle as the line-completing handshake's next cycle. No extra pixel is accepted.

## Configuration
- LINE_FEED_PAD_EN:
  - Defined: the scheduler emits one all-zero line (o_pix_valid=1, o_pix_data=0, o_src_ready=0, one pixel per cycle) before the first source line and after the last. Padding lines consume credit like source lines. Total lines = IMG_HEIGHT+2 and expected interrupts = IMG_HEIGHT.
  - Undefined: no padding. Total lines = IMG_HEIGHT, expected interrupts = IMG_HEIGHT−2.

## Structure
- Package lfs_pkg: state enum (IDLE/FEED/DRAIN/DONE), width localparam functions, and total-line/expected-interrupt constants derived from the macro.
- One sub-module, lfs_credit_counter. It holds the saturating up/down credit with simultaneous inc/dec handling and the error flag output.
- FSM, column/line counters and output register live in the top module.

## Test plan
Bench parameters: IMG_WIDTH=8, IMG_HEIGHT=6, PREFILL_LINES=4, macro off unless stated.
- Prefill: start, source always valid, no intr → exactly 32 pixels forwarded in 32 consecutive cycles, then o_src_ready=0 indefinitely.
- Credit release: after prefill, pulse i_lb_intr once → exactly 8 more pixels accepted. A second pulse → the last 8 accepted, state DRAIN.
- Completion: 4 total intr pulses → o_frame_done high one cycle after the 4th, o_busy 0 the same cycle. A 5th pulse sets o_err_intr.
- Simultaneous: intr in the same cycle as a line-completing handshake → credit unchanged, no error, pixel count still correct.
- Reset mid-frame: drop i_rst_n after 13 pixels → all outputs reset, no frame_done. A new start forwards 32 pixels again.
- LINE_FEED_PAD_EN: start → first 8 o_pix_valid cycles carry 0 with o_src_ready=0, followed by 24 source pixels. o_frame_done comes after 6 intr pulses.
